lsu_data_port: RTL and testbench
================================

LSU_DATA_PORT -- requirements
Module: lsu_data_port

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous active-high reset.
REQ-003 req_valid  input  1  pipeline requests a load/store this cycle; held stable until done_valid or req_error.
REQ-004 req_we  input  1  1=store, 0=load.
REQ-005 req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data, right-justified.
REQ-008 stall  output  1  pipeline must hold; combinational.
REQ-009 done_valid  output  1  one-cycle pulse: access complete.
REQ-010 load_data  output  32  extended load result, valid while done_valid.
REQ-011 req_error  output  1  combinational; misaligned or illegal funct3 request.
REQ-012 mem_read  output  1  data-port read strobe to memory.
REQ-013 mem_write  output  1  data-port write strobe to memory.
REQ-014 mem_address  output  32  word-aligned address (bits[1:0]=00).
REQ-015 mem_wmask  output  4  byte enables; bit i = byte lane i (bits 8i+7:8i).
REQ-016 mem_wdata  output  32  lane-aligned store data.
REQ-017 mem_rdata  input  32  read data, valid with mem_resp.
REQ-018 mem_resp  input  1  memory response for current strobe.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE; all memory-side outputs registered.
REQ-020 IDLE: req_valid and legal request -> latch addr/funct3/we, drive mem_read=!req_we or mem_write=req_we from next cycle, go ACCESS.
REQ-021 Illegal request: funct3 in {011,110,111}, or H/HU with addr[0]=1, or W with addr[1:0]!=00 -> req_error=1 in IDLE, stall=0, no strobe, stay IDLE.
REQ-022 ACCESS: hold mem_read/mem_write, address, wmask, wdata constant until mem_resp=1; no timeout; mem_resp outside ACCESS ignored.
REQ-023 ACCESS with mem_resp=1: deassert strobes next cycle, capture extended load_data, go DONE.
REQ-024 DONE: done_valid=1, stall=0 for exactly one cycle, no new request accepted, go IDLE next cycle.
REQ-025 stall = (IDLE and req_valid and legal) or ACCESS; 0 in DONE and when idle.
REQ-026 mem_address = {req_addr[31:2],2'b00}.
REQ-027 wmask store: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111; loads drive wmask=0000.
REQ-028 wdata store: B data[7:0] replicated 4x; H data[15:0] replicated 2x; W data.
REQ-029 Load extract: lane = mem_rdata>>(8*addr[1:0]); B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
REQ-030 Stores: load_data=0 on done_valid.
REQ-031 Minimum latency: request in IDLE at edge 0 -> strobe cycle 1 -> resp earliest cycle 2 -> done_valid cycle 3.
REQ-032 Strobes mutually exclusive; never both high.

Reset
REQ-033 rst=1 -> state IDLE; mem_read, mem_write, mem_address, mem_wmask, mem_wdata, done_valid, load_data all 0 after edge.
REQ-034 rst in ACCESS aborts access: strobes low next cycle, no done_valid, later mem_resp ignored.
REQ-035 rst has priority over all other inputs in the same cycle.

Verification
REQ-036 LW addr 0x100, mem word 0xDEADBEEF, resp 1 cycle after strobe -> mem_read=1 address 0x100 wmask 0000, done_valid cycle 3, load_data 0xDEADBEEF.
REQ-037 LB addr 0x103, word 0x80FF7F01 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
REQ-038 SB addr 0x202 data 0x000000AB -> mem_write=1 address 0x200 wmask 0100 wdata 0xABABABAB; SH addr 0x202 data 0x1234 -> wmask 1100 wdata 0x12341234.
REQ-039 LW addr 0x101, and funct3=011 -> req_error=1, stall=0, no strobe for 5 cycles.
REQ-040 mem_resp delayed 7 cycles -> strobe/address/wmask/wdata constant 7 cycles, stall=1 throughout, single done_valid pulse.
REQ-041 rst asserted in 2nd ACCESS cycle, then resp -> strobes 0 next cycle, done_valid never 1, next request completes normally.

Source files
------------

// File: rtl/lsu_data_port.sv
// Load/store data port: turns one pipeline load/store into a single registered
// memory strobe. It also aligns store lanes and extends load data.
module lsu_data_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done_valid,
    output logic [31:0] load_data,
    output logic        req_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic [1:0]  dbg_state
);

    // Handshake: req_valid stays high until done_valid or req_error; a strobe stays
    // constant until mem_resp is seen in ACCESS; mem_resp at any other time is ignored.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        illegal;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b001, 3'b101:         illegal = req_addr[0];
            3'b010:                 illegal = (req_addr[1:0] != 2'b00);
            default:                illegal = 1'b0;
        endcase
    end

    // Store size comes from funct3[1:0], so the lane placement is the same for signed and unsigned codes.
    always_comb begin
        st_mask = 4'b1111;
        st_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << {req_addr[1], 1'b0};
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_lo_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wmask_d   = mem_wmask_q;
        mem_wdata_d   = mem_wdata_q;
        load_data_d   = load_data_q;
        funct3_d      = funct3_q;
        addr_lo_d     = addr_lo_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !illegal) begin
                    state_d       = ACCESS;
                    mem_read_d    = !req_we;
                    mem_write_d   = req_we;
                    mem_address_d = {req_addr[31:2], 2'b00};
                    mem_wmask_d   = req_we ? st_mask : 4'b0000;
                    mem_wdata_d   = req_we ? st_data : 32'd0;
                    funct3_d      = req_funct3;
                    addr_lo_d     = req_addr[1:0];
                end
            end
            ACCESS: begin
                if (mem_resp) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    load_data_d = mem_write_q ? 32'd0 : rd_ext;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'd0;
            mem_wmask_q   <= 4'd0;
            mem_wdata_q   <= 32'd0;
            load_data_q   <= 32'd0;
            funct3_q      <= 3'd0;
            addr_lo_q     <= 2'd0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wmask_q   <= mem_wmask_d;
            mem_wdata_q   <= mem_wdata_d;
            load_data_q   <= load_data_d;
            funct3_q      <= funct3_d;
            addr_lo_q     <= addr_lo_d;
        end
    end

    assign stall       = ((state_q == IDLE) && req_valid && !illegal) || (state_q == ACCESS);
    assign req_error   = (state_q == IDLE) && req_valid && illegal;
    assign done_valid  = (state_q == DONE);
    assign load_data   = load_data_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port: directed and random loads/stores against a
// transaction-level model of lane placement and load extension.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done_valid;
  logic [31:0] load_data;
  logic        req_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  lsu_data_port dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done_valid(done_valid), .load_data(load_data),
    .req_error(req_error), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // strobes must never both be high, checked away from the edge
  always @(negedge clk) begin
    n_vec++;
    if (mem_read && mem_write) begin
      n_bad++;
      $display("FAIL strobe_excl: read=%0b write=%0b both high", mem_read, mem_write);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: byte enables cover 2^size bytes starting at the byte offset
  function automatic logic [3:0] m_mask(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!we) return 4'b0000;
    n = 1 << f3[1:0];
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic we, input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    if (!we) return 32'd0;
    r = d;
    for (int i = 0; i < 4; i++) begin
      if (f3[1:0] == 2'b00) r[8*i +: 8] = d[7:0];
      if (f3[1:0] == 2'b01) r[8*i +: 8] = d[8*(i%2) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    longint v;
    int nbytes;
    v = 0;
    nbytes = 1 << f3[1:0];
    for (int i = 0; i < nbytes; i++) v = v + (longint'(w[8*(a[1:0]+i) +: 8]) << (8*i));
    if (!f3[2] && nbytes < 4 && v >= (64'sd1 << (8*nbytes - 1))) v = v - (64'sd1 << (8*nbytes));
    return v[31:0];
  endfunction

  // driver: full transaction, checking every strobe cycle and the done cycle
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int delay, input logic [31:0] rd,
                        output logic [3:0] got_mask, output logic [31:0] got_wdata,
                        output logic [31:0] got_ld);
    logic [31:0] exp_q[$];
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    chk("req_stall", {31'd0, stall}, 32'd1);
    chk("req_err", {31'd0, req_error}, 32'd0);
    exp_q.push_back(we ? 32'd0 : m_load(f3, a, rd));
    step();
    got_mask = mem_wmask;
    got_wdata = mem_wdata;
    for (int k = 0; k <= delay; k++) begin
      chk("acc_read", {31'd0, mem_read}, {31'd0, !we});
      chk("acc_write", {31'd0, mem_write}, {31'd0, we});
      chk("acc_addr", mem_address, {a[31:2], 2'b00});
      chk("acc_mask", {28'd0, mem_wmask}, {28'd0, m_mask(we, f3, a)});
      chk("acc_wdata", mem_wdata, m_wdata(we, f3, wd));
      chk("acc_stall", {31'd0, stall}, 32'd1);
      chk("acc_done", {31'd0, done_valid}, 32'd0);
      if (k == delay) begin
        mem_resp = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      step();
    end
    mem_resp = 1'b0;
    got_ld = load_data;
    chk("done_valid", {31'd0, done_valid}, 32'd1);
    chk("done_data", load_data, exp_q.pop_front());
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    req_valid = 1'b0;
    mem_resp = $urandom_range(0, 1);
    step();
    chk("post_done", {31'd0, done_valid}, 32'd0);
    chk("post_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    mem_resp = 1'b0;
  endtask

  task automatic do_illegal(input logic [2:0] f3, input logic [31:0] a, input int cycles);
    req_valid = 1'b1; req_we = $urandom_range(0, 1); req_funct3 = f3; req_addr = a;
    req_wdata = $urandom;
    for (int k = 0; k < cycles; k++) begin
      #1;
      chk("ill_err", {31'd0, req_error}, 32'd1);
      chk("ill_stall", {31'd0, stall}, 32'd0);
      chk("ill_strobe", {30'd0, mem_read, mem_write}, 32'd0);
      step();
    end
    req_valid = 1'b0;
    #1;
    chk("ill_clear", {31'd0, req_error}, 32'd0);
  endtask

  logic [3:0]  g_mask;
  logic [31:0] g_wdata, g_ld;

  initial begin
    rst = 1'b1; req_valid = $urandom_range(0, 1); req_we = $urandom_range(0, 1);
    req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = $urandom;
    mem_rdata = $urandom; mem_resp = 1'b1;
    step();
    step();
    chk("rst_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_mask", {28'd0, mem_wmask}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_done", {31'd0, done_valid}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    rst = 1'b0; req_valid = 1'b0; mem_resp = 1'b0;
    step();

    // directed cases with literal expectations
    do_txn(1'b0, 3'b010, 32'h100, 32'd0, 1, 32'hDEADBEEF, g_mask, g_wdata, g_ld);
    chk("lit_lw", g_ld, 32'hDEADBEEF);
    chk("lit_lw_mask", {28'd0, g_mask}, 32'd0);
    do_txn(1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h80FF7F01, g_mask, g_wdata, g_ld);
    chk("lit_lb", g_ld, 32'hFFFFFF80);
    do_txn(1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h80FF7F01, g_mask, g_wdata, g_ld);
    chk("lit_lbu", g_ld, 32'h00000080);
    do_txn(1'b0, 3'b001, 32'h102, 32'd0, 1, 32'h80FF7F01, g_mask, g_wdata, g_ld);
    chk("lit_lh", g_ld, 32'hFFFF80FF);
    do_txn(1'b1, 3'b000, 32'h202, 32'h000000AB, 1, $urandom, g_mask, g_wdata, g_ld);
    chk("lit_sb_mask", {28'd0, g_mask}, 32'h4);
    chk("lit_sb_data", g_wdata, 32'hABABABAB);
    chk("lit_sb_ld", g_ld, 32'd0);
    do_txn(1'b1, 3'b001, 32'h202, 32'h00001234, 1, $urandom, g_mask, g_wdata, g_ld);
    chk("lit_sh_mask", {28'd0, g_mask}, 32'hC);
    chk("lit_sh_data", g_wdata, 32'h12341234);
    do_txn(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 7, $urandom, g_mask, g_wdata, g_ld);

    do_illegal(3'b010, 32'h101, 5);
    do_illegal(3'b011, 32'h100, 5);
    do_illegal(3'b101, 32'h203, 2);
    do_illegal(3'b111, 32'h200, 2);

    // reset in the second ACCESS cycle aborts the access
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    step();
    chk("ab_read1", {31'd0, mem_read}, 32'd1);
    step();
    chk("ab_read2", {31'd0, mem_read}, 32'd1);
    rst = 1'b1; mem_resp = 1'b1;
    step();
    rst = 1'b0; req_valid = 1'b0;
    chk("ab_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    chk("ab_done", {31'd0, done_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ab_late_done", {31'd0, done_valid}, 32'd0);
      chk("ab_late_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    end
    mem_resp = 1'b0;
    do_txn(1'b0, 3'b100, 32'h401, 32'd0, 2, 32'h12345678, g_mask, g_wdata, g_ld);
    chk("ab_next", g_ld, 32'h00000056);

    // randomized legal traffic, occasional illegal request
    for (int t = 0; t < 60; t++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] a;
      int sz;
      we = $urandom_range(0, 1);
      sz = $urandom_range(0, 2);
      f3 = 3'(sz);
      if (!we && sz < 2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      a = $urandom;
      if (sz == 1) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
      do_txn(we, f3, a, $urandom, $urandom_range(1, 7), $urandom, g_mask, g_wdata, g_ld);
      if ($urandom_range(0, 5) == 0) do_illegal(3'b110, $urandom, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
